// File: rtl/clock_control_pkg.sv
// Shared types and default constants for the run/halt/step clock controller.
package clock_control_pkg;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } cc_state_t;

    localparam int CC_DEBOUNCE_DEFAULT = 4;
    localparam int CC_STEP_DEFAULT     = 1;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw active-low front-panel button, debounces its level and
// emits a one-cycle press pulse on each accepted 1->0 transition.
module button_debouncer
    import clock_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CC_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic _reset,
    input  logic _raw,
    output logic level,
    output logic press
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser; idles high so a released button reads as released.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= _raw;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                // Only the falling (press) edge is an event; release is silent.
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_control.sv
// Run/halt/single-step controller producing a registered, glitch-free clk_en
// for the CPU pulse generator.
module clock_control
    import clock_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CC_DEBOUNCE_DEFAULT,
    parameter int STEP_CYCLES     = CC_STEP_DEFAULT
) (
    input  logic clk,
    input  logic _reset,
    input  logic _run_sw,
    input  logic _step_sw,
    input  logic halt_req,
    output logic clk_en,
    output logic running,
    output logic stepping
);

    localparam int            SW        = $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES - 1);

    logic run_press;
    logic step_press;
    logic run_level_unused;
    logic step_level_unused;

    cc_state_t     state_q, state_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic          clk_en_q;
    logic          running_q;
    logic          stepping_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk    (clk),
        ._reset (_reset),
        ._raw   (_run_sw),
        .level  (run_level_unused),
        .press  (run_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk    (clk),
        ._reset (_reset),
        ._raw   (_step_sw),
        .level  (step_level_unused),
        .press  (step_press)
    );

    // Next-state decode; halt_req always dominates, run beats step from HALT.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            HALT: begin
                if (!halt_req) begin
                    if (run_press) begin
                        state_d = RUN;
                    end else if (step_press) begin
                        state_d    = STEP;
                        step_cnt_d = STEP_LOAD;
                    end
                end
            end
            RUN: begin
                if (halt_req || run_press) state_d = HALT;
            end
            STEP: begin
                if (halt_req || (step_cnt_q == '0)) begin
                    state_d = HALT;
                end else begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // State, step counter and outputs all load from the next-state decode on one edge.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q    <= HALT;
            step_cnt_q <= '0;
            clk_en_q   <= 1'b0;
            running_q  <= 1'b0;
            stepping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            clk_en_q   <= (state_d == RUN) || (state_d == STEP);
            running_q  <= (state_d == RUN);
            stepping_q <= (state_d == STEP);
        end
    end

    assign clk_en   = clk_en_q;
    assign running  = running_q;
    assign stepping = stepping_q;

endmodule

// File: tb/tb_clock_control.sv
// Scoreboard bench: stimulus queues expected outputs tagged with a cycle
// number, a negedge monitor pops and compares them.
module tb_clock_control;

    logic clk = 1'b0;
    logic rst_n;
    logic run_sw;
    logic step_sw;
    logic halt_req;
    logic clk_en;
    logic running;
    logic stepping;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int    cyc;
        logic  en;
        logic  run;
        logic  stp;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;

    clock_control #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(3)) dut (
        .clk      (clk),
        ._reset   (rst_n),
        ._run_sw  (run_sw),
        ._step_sw (step_sw),
        .halt_req (halt_req),
        .clk_en   (clk_en),
        .running  (running),
        .stepping (stepping)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic e, input logic r, input logic s, input string n);
        exp_t x;
        x.cyc = c; x.en = e; x.run = r; x.stp = s; x.name = n;
        sb.push_back(x);
    endtask

    task automatic step_to(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_x = sb.pop_front();
            checks++;
            if (mon_x.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed, now cycle %0d", mon_x.name, mon_x.cyc, cyc);
            end else if ({clk_en, running, stepping} !== {mon_x.en, mon_x.run, mon_x.stp}) begin
                errors++;
                $display("FAIL %s: cycle %0d en/run/step got %b%b%b expected %b%b%b", mon_x.name, cyc,
                         clk_en, running, stepping, mon_x.en, mon_x.run, mon_x.stp);
            end
        end
    end

    initial begin
        int p;
        int q;
        rst_n = 1'b0; run_sw = 1'b1; step_sw = 1'b1; halt_req = 1'b0;

        step_to(1);
        push(cyc, 0, 0, 0, "reset_vals");
        step_to(2);
        rst_n = 1'b1;
        step_to(1);

        // Run press, hold, release, second press halts.
        p = cyc; run_sw = 1'b0;
        push(p + 6, 0, 0, 0, "run_latency_pre");
        push(p + 7, 1, 1, 0, "run_on_e7");
        step_to(10); run_sw = 1'b1; step_to(10);
        push(cyc, 1, 1, 0, "run_release_no_event");
        p = cyc; run_sw = 1'b0;
        push(p + 6, 1, 1, 0, "run2_pre");
        push(p + 7, 0, 0, 0, "run2_halt");
        step_to(10); run_sw = 1'b1; step_to(10);

        // Three-sample bounce on STEP is rejected.
        p = cyc; step_sw = 1'b0;
        for (int i = 1; i <= 12; i++) push(p + i, 0, 0, 0, "bounce_quiet");
        step_to(3); step_sw = 1'b1; step_to(12);

        // Held STEP gives exactly one 3-cycle burst.
        p = cyc; step_sw = 1'b0;
        push(p + 6, 0, 0, 0, "step_pre");
        push(p + 7, 1, 0, 1, "step_burst1");
        push(p + 8, 1, 0, 1, "step_burst2");
        push(p + 9, 1, 0, 1, "step_burst3");
        push(p + 10, 0, 0, 0, "step_end");
        push(p + 14, 0, 0, 0, "step_no_repeat");
        step_to(15); step_sw = 1'b1; step_to(10);

        // halt_req in RUN stops on the sampling edge.
        p = cyc; run_sw = 1'b0;
        push(p + 7, 1, 1, 0, "run3_on");
        step_to(5); run_sw = 1'b1; step_to(10);
        push(cyc, 1, 1, 0, "pre_halt_req");
        halt_req = 1'b1;
        step_to(1); halt_req = 1'b0;
        push(cyc, 0, 0, 0, "halt_req_stop");
        push(cyc + 2, 0, 0, 0, "halt_req_stays");
        step_to(5);

        // Run press while halt_req held in HALT is discarded.
        p = cyc; halt_req = 1'b1; run_sw = 1'b0;
        push(p + 7, 0, 0, 0, "halt_blocks_run");
        push(p + 8, 0, 0, 0, "halt_blocks_run2");
        step_to(5); run_sw = 1'b1; step_to(10);
        halt_req = 1'b0; step_to(5);
        push(cyc, 0, 0, 0, "halt_run_lost");

        // Simultaneous presses: RUN wins.
        p = cyc; run_sw = 1'b0; step_sw = 1'b0;
        push(p + 6, 0, 0, 0, "simul_pre");
        push(p + 7, 1, 1, 0, "simul_run");
        push(p + 8, 1, 1, 0, "simul_run2");
        step_to(5); run_sw = 1'b1; step_sw = 1'b1; step_to(12);
        push(cyc, 1, 1, 0, "simul_still_run");

        // Asynchronous reset mid-RUN, with RUN held through deassertion.
        step_to(1);
        rst_n = 1'b0; run_sw = 1'b0;
        push(cyc, 0, 0, 0, "async_reset");
        step_to(3);
        rst_n = 1'b1; q = cyc;
        push(q + 2, 0, 0, 0, "post_reset");
        push(q + 6, 0, 0, 0, "held_reset_pre");
        push(q + 7, 1, 1, 0, "held_through_reset");
        step_to(10); run_sw = 1'b1; step_to(10);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
